// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the ctrl_sequencer control unit.
//   seq_state_e  - sequencer FSM states
//   ctrl_out_t   - registered control strobes driven toward decoder/datapath
//   ctrl_decode  - Moore output decode from (state, latched opCode[0])
package ctrl_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned WDOG_W = 4;

  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  // opCode[0] variant meanings, captured at DECODE
  localparam logic OP_VAR_MOVI  = 1'b1;  // MOV: immediate source via BRjEn
  localparam logic OP_VAR_STORE = 1'b1;  // load/store: store when set

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    LATCH    = 4'd2,
    DECODE   = 4'd3,
    ALU_A    = 4'd4,
    ALU_B    = 4'd5,
    MOV      = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_DATA = 4'd8,
    WB       = 4'd9,
    NOP      = 4'd10,
    HALT     = 4'd11
  } seq_state_e;

  typedef struct packed {
    logic fetch;
    logic ir;
    logic iri_en;
    logic irj_en;
    logic brj_en;
    logic mem_rd;
    logic mem_wr;
    logic mar_ld;
    logic reg_we;
    logic alu_go;
    logic pc_inc;
    logic halted;
  } ctrl_out_t;

  // Moore decode: strobes depend only on state and the latched variant bit
  function automatic ctrl_out_t ctrl_decode(input seq_state_e st, input logic variant);
    ctrl_out_t o;
    o = '0;
    case (st)
      FETCH:    begin o.fetch  = 1'b1; o.mem_rd = 1'b1; end
      LATCH:    begin o.ir     = 1'b1; o.mem_rd = 1'b1; end
      ALU_A:    begin o.iri_en = 1'b1; o.alu_go = 1'b1; end
      ALU_B:    o.irj_en = 1'b1;
      MOV: begin
        if (variant == OP_VAR_MOVI) o.brj_en = 1'b1;
        else                        o.irj_en = 1'b1;
      end
      MEM_ADDR: begin o.irj_en = 1'b1; o.mar_ld = 1'b1; end
      MEM_DATA: begin
        if (variant == OP_VAR_STORE) begin
          o.iri_en = 1'b1;
          o.mem_wr = 1'b1;
        end else begin
          o.mem_rd = 1'b1;
        end
      end
      WB:       begin o.iri_en = 1'b1; o.reg_we = 1'b1; o.pc_inc = 1'b1; end
      NOP:      o.pc_inc = 1'b1;
      HALT:     o.halted = 1'b1;
      default:  ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/seq_alu_wdog.sv
// seq_alu_wdog: ALU_B wait-cycle watchdog (built only with SEQ_ALU_TIMEOUT_EN).
//   clk, reset  - clock, synchronous active-low reset
//   clear_i     - cycle before ALU_B entry; counter restarts
//   run_i       - sequencer is in ALU_B; count this cycle
//   expire_o    - registered: current ALU_B cycle is the LIMIT-th one
module seq_alu_wdog
  import ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  // Counter holds (ALU_B cycles elapsed - 1) while in ALU_B
  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 1);

  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              expire_q, expire_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)    cnt_d = '0;
    else if (run_i) cnt_d = cnt_q + WDOG_W'(1);
    // Flag precomputed so it lines up with the cycle the count refers to
    expire_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: control-unit FSM sequencing fetch/latch/decode/execute/writeback.
// Optional macro SEQ_ALU_TIMEOUT_EN adds an ALU_B timeout (alu_err), else alu_err=0.
//   clk, reset            - clock, synchronous active-low reset
//   start                 - leave IDLE
//   mem_ready, alu_done   - memory / ALU completion
//   opCode, ALUstr, MOVstr, LDSRstr - decoder outputs sampled in DECODE
//   IF, IR, IRiEn, IRjEn, BRjEn     - decoder strobes/enables
//   mem_rd, mem_wr, mar_ld, reg_we, alu_go, pc_inc - datapath controls
//   halted, alu_err       - status
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mem_ready,
  input  logic [OP_W-1:0] opCode,
  input  logic            ALUstr,
  input  logic            MOVstr,
  input  logic            LDSRstr,
  input  logic            alu_done,
  output logic            IF,
  output logic            IR,
  output logic            IRiEn,
  output logic            IRjEn,
  output logic            BRjEn,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            mar_ld,
  output logic            reg_we,
  output logic            alu_go,
  output logic            pc_inc,
  output logic            halted,
  output logic            alu_err
);

  // Elaboration-time range guard on the timeout counter width
  if (ALU_TIMEOUT == 0 || ALU_TIMEOUT > ((2 ** WDOG_W) - 1)) begin : g_bad_timeout
    $error("ctrl_sequencer: ALU_TIMEOUT out of range");
  end

  seq_state_e state_q, state_d;
  logic       variant_q, variant_d;
  ctrl_out_t  out_q, out_d;

`ifdef SEQ_ALU_TIMEOUT_EN
  logic err_q, err_d;
  logic wdog_expire;

  seq_alu_wdog #(
    .LIMIT (ALU_TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q == ALU_A),
    .run_i    (state_q == ALU_B),
    .expire_o (wdog_expire)
  );
`endif

  // Next-state; outputs are decoded from the next state and registered
  always_comb begin
    state_d   = state_q;
    variant_d = variant_q;
`ifdef SEQ_ALU_TIMEOUT_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE:     if (start) state_d = FETCH;
      FETCH:    if (mem_ready) state_d = LATCH;
      LATCH:    state_d = DECODE;
      DECODE: begin
        variant_d = opCode[0];
        if (LDSRstr)                 state_d = MEM_ADDR;
        else if (MOVstr)             state_d = MOV;
        else if (ALUstr)             state_d = ALU_A;
        else if (opCode == OP_HALT)  state_d = HALT;
        else                         state_d = NOP;
      end
      ALU_A:    state_d = ALU_B;
      ALU_B: begin
        // alu_done on the terminal count still completes normally
        if (alu_done) state_d = WB;
`ifdef SEQ_ALU_TIMEOUT_EN
        else if (wdog_expire) begin
          state_d = NOP;
          err_d   = 1'b1;
        end
`endif
      end
      MOV:      state_d = WB;
      MEM_ADDR: state_d = MEM_DATA;
      MEM_DATA: begin
        if (mem_ready) state_d = (variant_q == OP_VAR_STORE) ? NOP : WB;
      end
      WB:       state_d = FETCH;
      NOP:      state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
    out_d = ctrl_decode(state_d, variant_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      variant_q <= 1'b0;
      out_q     <= '0;
`ifdef SEQ_ALU_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      variant_q <= variant_d;
      out_q     <= out_d;
`ifdef SEQ_ALU_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign IF     = out_q.fetch;
  assign IR     = out_q.ir;
  assign IRiEn  = out_q.iri_en;
  assign IRjEn  = out_q.irj_en;
  assign BRjEn  = out_q.brj_en;
  assign mem_rd = out_q.mem_rd;
  assign mem_wr = out_q.mem_wr;
  assign mar_ld = out_q.mar_ld;
  assign reg_we = out_q.reg_we;
  assign alu_go = out_q.alu_go;
  assign pc_inc = out_q.pc_inc;
  assign halted = out_q.halted;

`ifdef SEQ_ALU_TIMEOUT_EN
  assign alu_err = err_q;
`else
  assign alu_err = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed, table-driven bench for ctrl_sequencer.
// Each row gives the inputs held over one rising edge and the full output
// vector expected right after that edge.
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, mem_ready, ALUstr, MOVstr, LDSRstr, alu_done;
  logic [3:0] opCode;
  logic       IF, IR, IRiEn, IRjEn, BRjEn, mem_rd, mem_wr, mar_ld;
  logic       reg_we, alu_go, pc_inc, halted, alu_err;

  always #5 clk = ~clk;

  ctrl_sequencer #(.ALU_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
    .opCode(opCode), .ALUstr(ALUstr), .MOVstr(MOVstr), .LDSRstr(LDSRstr),
    .alu_done(alu_done), .IF(IF), .IR(IR), .IRiEn(IRiEn), .IRjEn(IRjEn),
    .BRjEn(BRjEn), .mem_rd(mem_rd), .mem_wr(mem_wr), .mar_ld(mar_ld),
    .reg_we(reg_we), .alu_go(alu_go), .pc_inc(pc_inc), .halted(halted),
    .alu_err(alu_err)
  );

  // Output bit weights: {IF,IR,IRiEn,IRjEn,BRjEn,mem_rd,mem_wr,mar_ld,reg_we,alu_go,pc_inc,halted,alu_err}
  localparam logic [12:0] B_IF  = 13'h1000, B_IR  = 13'h0800, B_RI  = 13'h0400;
  localparam logic [12:0] B_RJ  = 13'h0200, B_BJ  = 13'h0100, B_RD  = 13'h0080;
  localparam logic [12:0] B_WR  = 13'h0040, B_MAR = 13'h0020, B_WE  = 13'h0010;
  localparam logic [12:0] B_GO  = 13'h0008, B_PC  = 13'h0004, B_HLT = 13'h0002;
  localparam logic [12:0] B_ERR = 13'h0001;

  localparam logic [12:0] O_IDLE  = 13'h0000;
  localparam logic [12:0] O_FETCH = B_IF | B_RD;
  localparam logic [12:0] O_LATCH = B_IR | B_RD;
  localparam logic [12:0] O_DEC   = 13'h0000;
  localparam logic [12:0] O_ALUA  = B_RI | B_GO;
  localparam logic [12:0] O_ALUB  = B_RJ;
  localparam logic [12:0] O_MOVR  = B_RJ;
  localparam logic [12:0] O_MOVI  = B_BJ;
  localparam logic [12:0] O_MADDR = B_RJ | B_MAR;
  localparam logic [12:0] O_LOAD  = B_RD;
  localparam logic [12:0] O_STORE = B_RI | B_WR;
  localparam logic [12:0] O_WB    = B_RI | B_WE | B_PC;
  localparam logic [12:0] O_NOP   = B_PC;
  localparam logic [12:0] O_HALT  = B_HLT;

  wire [12:0] obs = {IF, IR, IRiEn, IRjEn, BRjEn, mem_rd, mem_wr, mar_ld,
                     reg_we, alu_go, pc_inc, halted, alu_err};

  typedef struct {
    logic        rst_n;
    logic        st;
    logic        rdy;
    logic [3:0]  op;
    logic        alu;
    logic        mov;
    logic        ldsr;
    logic        done;
    logic [12:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic m,
                              input logic [3:0] op, input logic a, input logic mv,
                              input logic ld, input logic d,
                              input logic [12:0] e, input string t);
    vec_t x;
    x.rst_n = r; x.st = s; x.rdy = m; x.op = op;
    x.alu = a; x.mov = mv; x.ldsr = ld; x.done = d;
    x.exp = e; x.tag = t;
    return x;
  endfunction

  task automatic add(input logic r, input logic s, input logic m,
                     input logic [3:0] op, input logic a, input logic mv,
                     input logic ld, input logic d,
                     input logic [12:0] e, input string t);
    vecs.push_back(mk(r, s, m, op, a, mv, ld, d, e, t));
  endtask

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    reset = x.rst_n; start = x.st; mem_ready = x.rdy; opCode = x.op;
    ALUstr = x.alu; MOVstr = x.mov; LDSRstr = x.ldsr; alu_done = x.done;
    @(posedge clk);
    #1;
    check(x.tag, obs, x.exp);
    check({x.tag, "/excl"}, 13'(!(IRiEn && IRjEn) && !(BRjEn && IRjEn)), 13'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0; opCode = 4'h0;
    ALUstr = 1'b0; MOVstr = 1'b0; LDSRstr = 1'b0; alu_done = 1'b0;

    //   r  s  m  op     a  mv ld d   expected  tag
    add(0, 0, 0, 4'h0, 0, 0, 0, 0, O_IDLE,  "rst0");
    add(0, 0, 0, 4'h0, 0, 0, 0, 0, O_IDLE,  "rst1");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_IDLE,  "idle_hold");
    // reset held 3 cycles mid-FETCH, mem_ready high to show reset wins
    add(1, 1, 0, 4'h0, 0, 0, 0, 0, O_FETCH, "f_start");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_FETCH, "f_wait");
    add(0, 0, 1, 4'h0, 0, 0, 0, 0, O_IDLE,  "midrst0");
    add(0, 1, 1, 4'h0, 0, 0, 0, 0, O_IDLE,  "midrst1");
    add(0, 0, 0, 4'h0, 0, 0, 0, 0, O_IDLE,  "midrst2");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_IDLE,  "post_rst_idle");
    // ALU: alu_done during ALU_A is ignored, real done on 2nd ALU_B cycle
    add(1, 1, 0, 4'h0, 0, 0, 0, 0, O_FETCH, "alu_fetch");
    add(1, 0, 1, 4'h0, 0, 0, 0, 0, O_LATCH, "alu_latch");
    add(1, 0, 0, 4'h0, 1, 0, 0, 0, O_DEC,   "alu_dec");
    add(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUA,  "alu_a");
    add(1, 0, 0, 4'h0, 1, 0, 0, 1, O_ALUB,  "alu_b1");
    add(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUB,  "alu_b2");
    add(1, 0, 0, 4'h0, 1, 0, 0, 1, O_WB,    "alu_wb");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_FETCH, "alu_refetch");
    // MOV immediate
    add(1, 0, 1, 4'h9, 0, 1, 0, 0, O_LATCH, "movi_latch");
    add(1, 0, 0, 4'h9, 0, 1, 0, 0, O_DEC,   "movi_dec");
    add(1, 0, 0, 4'h9, 0, 1, 0, 0, O_MOVI,  "movi_mov");
    add(1, 0, 0, 4'h9, 0, 1, 0, 0, O_WB,    "movi_wb");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_FETCH, "movi_fetch");
    // MOV register
    add(1, 0, 1, 4'h8, 0, 1, 0, 0, O_LATCH, "movr_latch");
    add(1, 0, 0, 4'h8, 0, 1, 0, 0, O_DEC,   "movr_dec");
    add(1, 0, 0, 4'h8, 0, 1, 0, 0, O_MOVR,  "movr_mov");
    add(1, 0, 0, 4'h8, 0, 1, 0, 0, O_WB,    "movr_wb");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_FETCH, "movr_fetch");
    // store with MOVstr also set: LDSR priority, mem_ready after 3 waits
    add(1, 0, 1, 4'h3, 0, 1, 1, 0, O_LATCH, "st_latch");
    add(1, 0, 0, 4'h3, 0, 1, 1, 0, O_DEC,   "st_dec");
    add(1, 0, 0, 4'h3, 0, 1, 1, 0, O_MADDR, "st_addr");
    add(1, 0, 0, 4'h3, 0, 1, 1, 0, O_STORE, "st_data1");
    add(1, 0, 0, 4'h3, 0, 1, 1, 0, O_STORE, "st_data2");
    add(1, 0, 0, 4'h3, 0, 1, 1, 0, O_STORE, "st_data3");
    add(1, 0, 0, 4'h3, 0, 1, 1, 0, O_STORE, "st_data4");
    add(1, 0, 1, 4'h3, 0, 1, 1, 0, O_NOP,   "st_done");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_FETCH, "st_fetch");
    // load
    add(1, 0, 1, 4'h2, 0, 0, 1, 0, O_LATCH, "ld_latch");
    add(1, 0, 0, 4'h2, 0, 0, 1, 0, O_DEC,   "ld_dec");
    add(1, 0, 0, 4'h2, 0, 0, 1, 0, O_MADDR, "ld_addr");
    add(1, 0, 0, 4'h2, 0, 0, 1, 0, O_LOAD,  "ld_data");
    add(1, 0, 1, 4'h2, 0, 0, 1, 0, O_WB,    "ld_wb");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_FETCH, "ld_fetch");
    // NOP
    add(1, 0, 1, 4'h0, 0, 0, 0, 0, O_LATCH, "nop_latch");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_DEC,   "nop_dec");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_NOP,   "nop");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_FETCH, "nop_fetch");
    // HALT absorbs start, reset releases it
    add(1, 0, 1, 4'hF, 0, 0, 0, 0, O_LATCH, "halt_latch");
    add(1, 0, 0, 4'hF, 0, 0, 0, 0, O_DEC,   "halt_dec");
    add(1, 0, 0, 4'hF, 0, 0, 0, 0, O_HALT,  "halt");
    add(1, 1, 0, 4'hF, 0, 0, 0, 0, O_HALT,  "halt_start1");
    add(1, 0, 0, 4'hF, 0, 0, 0, 0, O_HALT,  "halt_start0");
    add(1, 1, 1, 4'hF, 0, 0, 0, 0, O_HALT,  "halt_start2");
    add(0, 0, 0, 4'hF, 0, 0, 0, 0, O_IDLE,  "halt_rst");
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, O_IDLE,  "halt_idle");

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Latency: ALU instruction with immediate handshakes, FETCH to FETCH
    apply(mk(1, 1, 1, 4'h0, 1, 0, 0, 1, O_FETCH, "lat_fetch"));
    start = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (IF) begin
        n = k;
        break;
      end
    end
    check("lat_cycles", 13'(n), 13'd6);

`ifdef SEQ_ALU_TIMEOUT_EN
    // alu_done on the terminal (4th) ALU_B cycle wins: WB, no error
    apply(mk(1, 0, 1, 4'h0, 1, 0, 0, 0, O_LATCH, "to_win_latch"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_DEC,   "to_win_dec"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUA,  "to_win_a"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUB,  "to_win_b1"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUB,  "to_win_b2"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUB,  "to_win_b3"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUB,  "to_win_b4"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 1, O_WB,    "to_win_wb"));
    apply(mk(1, 0, 1, 4'h0, 0, 0, 0, 0, O_FETCH, "to_win_fetch"));
    // no alu_done: 4 ALU_B cycles then NOP with sticky alu_err
    apply(mk(1, 0, 1, 4'h0, 1, 0, 0, 0, O_LATCH, "to_latch"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_DEC,   "to_dec"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUA,  "to_a"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUB,  "to_b1"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUB,  "to_b2"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUB,  "to_b3"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_ALUB,  "to_b4"));
    apply(mk(1, 0, 0, 4'h0, 1, 0, 0, 0, O_NOP | B_ERR,   "to_nop"));
    apply(mk(1, 0, 0, 4'h0, 0, 0, 0, 0, O_FETCH | B_ERR, "to_fetch"));
    apply(mk(1, 0, 1, 4'h0, 0, 0, 0, 0, O_LATCH | B_ERR, "to_sticky_latch"));
    apply(mk(1, 0, 0, 4'h0, 0, 0, 0, 0, O_DEC | B_ERR,   "to_sticky_dec"));
    apply(mk(1, 0, 0, 4'h0, 0, 0, 0, 0, O_NOP | B_ERR,   "to_sticky_nop"));
    apply(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, O_IDLE,          "to_rst"));
    apply(mk(1, 0, 0, 4'h0, 0, 0, 0, 0, O_IDLE,          "to_idle"));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
